// File: rtl/div_unit.sv
// Iterative restoring signed divider: hi = remainder, lo = quotient (MIPS DIV); latency WIDTH+1 cycles.
// start is ignored while busy; define DIV_UNSIGNED_EN to add the unsigned_op port for DIVU.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIV_UNSIGNED_EN
    input  logic             unsigned_op,
`endif
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             quo_neg;
    logic             rem_neg;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~unsigned_op;
`else
    assign signed_op = 1'b1;
`endif

    // Magnitudes are taken as unsigned WIDTH-bit values, so |-2^(WIDTH-1)| still fits.
    assign a_neg = signed_op & a[WIDTH-1];
    assign b_neg = signed_op & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // The shifted remainder is below 2*divisor, so bit WIDTH of trial is a reliable sign.
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            quo      <= '0;
            rem      <= '0;
            divisor  <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b == '0) begin
                            div_zero <= 1'b1;
                        end else begin
                            quo     <= a_mag;
                            divisor <= b_mag;
                            rem     <= '0;
                            count   <= '0;
                            quo_neg <= a_neg ^ b_neg;
                            rem_neg <= a_neg;
                            busy    <= 1'b1;
                            state   <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= shifted[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], 1'b0};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    lo    <= quo_neg ? -quo : quo;
                    hi    <= rem_neg ? -rem : rem;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit (WIDTH = 32): latency, signs, zero divisor, overflow corner, ignored start, reset.
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        unsigned_op = 1'b0;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    div_unit #(.WIDTH(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
`ifdef DIV_UNSIGNED_EN
        .unsigned_op(unsigned_op),
`endif
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    // Starts a division and waits (bounded) for done. lat = edges from acceptance to done, -1 on timeout.
    // If inject > 0, a second start (1/1) is presented during cycle 'inject' of the division.
    task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input int inject,
                           output int lat, output int busy_cyc);
        @(negedge clock);
        a = av; b = bv; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = -1;
        busy_cyc = busy ? 1 : 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (k == inject) begin
                a = 32'd1; b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cyc++;
        end
        start = 1'b0;
    endtask

    int lat;
    int bcyc;
    int extra_done;

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_dz", {31'b0, div_zero}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // 7 / 2
        run_div(32'd7, 32'd2, 0, lat, bcyc);
        check("pos_lat", lat, 32'd33);
        check("pos_busy_cycles", bcyc, 32'd33);
        check("pos_lo", lo, 32'd3);
        check("pos_hi", hi, 32'd1);
        @(posedge clock); #1;
        check("pos_done_one_cycle", {31'b0, done}, 32'h0);

        // -7 / 2
        run_div(32'hFFFF_FFF9, 32'd2, 0, lat, bcyc);
        check("negdvd_lo", lo, 32'hFFFF_FFFD);
        check("negdvd_hi", hi, 32'hFFFF_FFFF);

        // 7 / -2
        run_div(32'd7, 32'hFFFF_FFFE, 0, lat, bcyc);
        check("negdvs_lo", lo, 32'hFFFF_FFFD);
        check("negdvs_hi", hi, 32'd1);

        // 5 / 0
        @(negedge clock);
        a = 32'd5; b = 32'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("dz_pulse", {31'b0, div_zero}, 32'h1);
        check("dz_busy", {31'b0, busy}, 32'h0);
        @(posedge clock); #1;
        check("dz_pulse_end", {31'b0, div_zero}, 32'h0);
        check("dz_busy_after", {31'b0, busy}, 32'h0);
        check("dz_done", {31'b0, done}, 32'h0);
        check("dz_lo_kept", lo, 32'hFFFF_FFFD);
        check("dz_hi_kept", hi, 32'd1);

        // -2^31 / -1
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcyc);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        // 100 / 7 with a start pulse presented at cycle 10
        run_div(32'd100, 32'd7, 10, lat, bcyc);
        check("ign_lat", lat, 32'd33);
        check("ign_lo", lo, 32'd14);
        check("ign_hi", hi, 32'd2);
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock); #1;
            if (done) extra_done++;
        end
        check("ign_extra_done", extra_done, 32'd0);
        check("ign_busy_idle", {31'b0, busy}, 32'h0);

        // Reset during cycle 15 of a division
        @(negedge clock);
        a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 32'h0);
        check("mid_rst_done", {31'b0, done}, 32'h0);
        check("mid_rst_hi", hi, 32'h0);
        check("mid_rst_lo", lo, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        run_div(32'd9, 32'd3, 0, lat, bcyc);
        check("post_rst_lat", lat, 32'd33);
        check("post_rst_lo", lo, 32'd3);
        check("post_rst_hi", hi, 32'd0);

        // Back-to-back: accepted on the cycle done is visible; -20 / 6
        run_div(32'hFFFF_FFEC, 32'd6, 0, lat, bcyc);
        check("b2b_lat", lat, 32'd33);
        check("b2b_lo", lo, 32'hFFFF_FFFD);
        check("b2b_hi", hi, 32'hFFFF_FFFE);

`ifdef DIV_UNSIGNED_EN
        unsigned_op = 1'b1;
        run_div(32'hFFFF_FFFE, 32'd2, 0, lat, bcyc);
        check("divu_lat", lat, 32'd33);
        check("divu_lo", lo, 32'h7FFF_FFFF);
        check("divu_hi", hi, 32'h0);
        unsigned_op = 1'b0;
        run_div(32'hFFFF_FFFE, 32'd2, 0, lat, bcyc);
        check("divs_lo", lo, 32'hFFFF_FFFF);
        check("divs_hi", hi, 32'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
